// File: rtl/alu_cmd_sequencer.sv
// Command FIFO plus issue/settle/capture sequencer in front of the combinational 4-bit ALU.
// Optional feature macro ALU_SEQ_CHAIN_EN: cmd_chain feeds the previous result back as operand a.
module alu_cmd_sequencer #(
    parameter int DEPTH  = 4,
    parameter int SETTLE = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [3:0] cmd_op,
    input  logic [3:0] cmd_a,
    input  logic [3:0] cmd_b,
`ifdef ALU_SEQ_CHAIN_EN
    input  logic       cmd_chain,
`endif
    output logic [3:0] alu_opcode,
    output logic [3:0] alu_a,
    output logic [3:0] alu_b,
    input  logic [3:0] alu_x,
    input  logic [3:0] alu_y,
    output logic       rsp_valid,
    input  logic       rsp_ready,
    output logic [3:0] rsp_x,
    output logic [3:0] rsp_y,
    output logic [3:0] rsp_op,
    output logic       busy
);
    localparam int AW = $clog2(DEPTH);
`ifdef ALU_SEQ_CHAIN_EN
    localparam int EW = 13;
`else
    localparam int EW = 12;
`endif
    localparam logic [AW:0] FULL        = (AW + 1)'(DEPTH);
    localparam logic [1:0]  SETTLE_LAST = 2'(SETTLE - 1);

    typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, RESP = 2'd2} state_t;

    state_t        state_q, state_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic [1:0]    cnt_q, cnt_d;
    logic [3:0]    alu_opcode_q, alu_opcode_d, alu_a_q, alu_a_d, alu_b_q, alu_b_d;
    logic [3:0]    rsp_x_q, rsp_x_d, rsp_y_q, rsp_y_d, rsp_op_q, rsp_op_d;
    logic          rsp_valid_q, rsp_valid_d;
    logic [EW-1:0] mem_q [DEPTH];
    logic [EW-1:0] head;
    logic          push, pop;
    logic [7:0]    masked;
`ifdef ALU_SEQ_CHAIN_EN
    logic [3:0]    last_q, last_d;
`endif

    // Keep only the result bits the ALU actually drives for this opcode; returns {y, x}.
    function automatic logic [7:0] mask_result(input logic [3:0] op, input logic [3:0] x,
                                               input logic [3:0] y);
        logic [7:0] r;
        case (op)
            4'h0, 4'h1, 4'h2, 4'h6, 4'h7, 4'h8, 4'h9: r = {4'h0, 3'b000, x[0]};
            4'hA:                                     r = {3'b000, y[0], x};
            4'hC, 4'hD, 4'hE:                         r = {y, x};
            default:                                  r = {4'h0, x};
        endcase
        return r;
    endfunction

    assign cmd_ready = (count_q != FULL);
    assign push      = cmd_valid && cmd_ready;
    assign busy      = (state_q != IDLE) || (count_q != '0);
    assign head      = mem_q[rd_ptr_q];
    assign masked    = mask_result(alu_opcode_q, alu_x, alu_y);

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        alu_opcode_d = alu_opcode_q;
        alu_a_d      = alu_a_q;
        alu_b_d      = alu_b_q;
        rsp_x_d      = rsp_x_q;
        rsp_y_d      = rsp_y_q;
        rsp_op_d     = rsp_op_q;
        rsp_valid_d  = rsp_valid_q;
        pop          = 1'b0;
`ifdef ALU_SEQ_CHAIN_EN
        last_d       = last_q;
`endif
        case (state_q)
            IDLE: begin
                if (count_q != '0) begin
                    pop     = 1'b1;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                if (cnt_q == SETTLE_LAST) begin
                    rsp_x_d     = masked[3:0];
                    rsp_y_d     = masked[7:4];
                    rsp_op_d    = alu_opcode_q;
                    rsp_valid_d = 1'b1;
                    state_d     = RESP;
`ifdef ALU_SEQ_CHAIN_EN
                    last_d      = masked[3:0];
`endif
                end else begin
                    cnt_d = cnt_q + 2'd1;
                end
            end
            RESP: begin
                // A waiting command is issued on the same edge the response is taken.
                if (rsp_valid_q && rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    if (count_q != '0) begin
                        pop     = 1'b1;
                        state_d = ISSUE;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if (pop) begin
            alu_opcode_d = head[11:8];
            alu_b_d      = head[3:0];
            cnt_d        = 2'd0;
`ifdef ALU_SEQ_CHAIN_EN
            alu_a_d      = head[12] ? last_q : head[7:4];
`else
            alu_a_d      = head[7:4];
`endif
        end

        wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
        count_d  = count_q;
        if (push && !pop)      count_d = count_q + (AW + 1)'(1);
        else if (pop && !push) count_d = count_q - (AW + 1)'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            cnt_q        <= 2'd0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            alu_opcode_q <= 4'h0;
            alu_a_q      <= 4'h0;
            alu_b_q      <= 4'h0;
            rsp_x_q      <= 4'h0;
            rsp_y_q      <= 4'h0;
            rsp_op_q     <= 4'h0;
            rsp_valid_q  <= 1'b0;
`ifdef ALU_SEQ_CHAIN_EN
            last_q       <= 4'h0;
`endif
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            alu_opcode_q <= alu_opcode_d;
            alu_a_q      <= alu_a_d;
            alu_b_q      <= alu_b_d;
            rsp_x_q      <= rsp_x_d;
            rsp_y_q      <= rsp_y_d;
            rsp_op_q     <= rsp_op_d;
            rsp_valid_q  <= rsp_valid_d;
`ifdef ALU_SEQ_CHAIN_EN
            last_q       <= last_d;
`endif
        end
    end

    // Storage needs no reset: occupancy is tracked by count_q alone.
    always_ff @(posedge clk) begin
        if (push) begin
`ifdef ALU_SEQ_CHAIN_EN
            mem_q[wr_ptr_q] <= {cmd_chain, cmd_op, cmd_a, cmd_b};
`else
            mem_q[wr_ptr_q] <= {cmd_op, cmd_a, cmd_b};
`endif
        end
    end

    assign alu_opcode = alu_opcode_q;
    assign alu_a      = alu_a_q;
    assign alu_b      = alu_b_q;
    assign rsp_x      = rsp_x_q;
    assign rsp_y      = rsp_y_q;
    assign rsp_op     = rsp_op_q;
    assign rsp_valid  = rsp_valid_q;

endmodule
